// File: rtl/instruction_fetch_queue_if.sv
// Signal bundle between the fetch queue, instruction memory, redirect logic and decoder.
// "master" is the fetch-queue side; "slave" is the environment around it.
interface instruction_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ready;
    logic [31:0]   mem_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          available;
    logic          decodePulse;
    logic [31:0]   instr;
    logic [31:0]   pcNumber;
    logic [CW-1:0] queue_count;

    modport master (
        output mem_req, mem_addr, decodePulse, instr, pcNumber, queue_count,
        input  mem_ready, mem_data, redirect_valid, redirect_pc, available
    );

    modport slave (
        input  mem_req, mem_addr, decodePulse, instr, pcNumber, queue_count,
        output mem_ready, mem_data, redirect_valid, redirect_pc, available
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Sequential instruction fetcher with a small PC-tagged FIFO feeding the decoder one word
// per decodePulse; a redirect flushes buffered entries and any in-flight fetch.
module instruction_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    instruction_fetch_queue_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pulse_q, pulse_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   pcn_q, pcn_d;
    logic          push;
    logic          pop;

    logic [31:0]   word_mem_q [DEPTH];
    logic [29:0]   pcn_mem_q  [DEPTH];

    logic          unused_pc_lsbs;
    assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

    // The occupancy check is only made in IDLE, where nothing is in flight, so a push never overflows.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.redirect_valid && (count_q < CW'(DEPTH))) begin
                    state_d    = WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!bus.redirect_valid) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (bus.redirect_valid) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        end
    end

    always_comb begin
        pop      = !pulse_q && (count_q != '0) && bus.available && !bus.redirect_valid;
        pulse_d  = pop;
        instr_d  = instr_q;
        pcn_d    = pcn_q;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (pop) begin
            instr_d = word_mem_q[rd_ptr_q];
            pcn_d   = {2'b00, pcn_mem_q[rd_ptr_q]};
        end
        if (bus.redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pulse_q    <= 1'b0;
            instr_q    <= '0;
            pcn_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pulse_q    <= pulse_d;
            instr_q    <= instr_d;
            pcn_q      <= pcn_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            word_mem_q[wr_ptr_q] <= bus.mem_data;
            pcn_mem_q[wr_ptr_q]  <= fetch_pc_q[31:2];
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.decodePulse = pulse_q;
    assign bus.instr       = instr_q;
    assign bus.pcNumber    = pcn_q;
    assign bus.queue_count = count_q;
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, and a latency-programmable memory responder.
module tb_instruction_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pcn;
    } entry_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    instruction_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    int memLat       = 1;
    bit overrideData = 1'b0;
    bit forceReady   = 1'b0;

    entry_t      pulseLog[$];
    logic [31:0] reqLog[$];

    entry_t      mq[$];
    logic        m_req, m_stale, m_pulse;
    logic [31:0] m_pc, m_addr, m_instr, m_pcn;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'hC000_0000 | addr;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] pc, input logic avail);
        bus.redirect_valid = redir;
        bus.redirect_pc    = pc;
        bus.available      = avail;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        step(2);
        pulseLog.delete();
        reqLog.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic waitPulses(input int n, input int budget, input string name);
        int cycles = 0;
        while (pulseLog.size() < n && cycles < budget) begin
            step(1);
            cycles++;
        end
        checkOutput(name, 32'(pulseLog.size() >= n), 32'd1);
    endtask

    task automatic waitReqs(input int n, input int budget, input string name);
        int cycles = 0;
        while (reqLog.size() < n && cycles < budget) begin
            step(1);
            cycles++;
        end
        checkOutput(name, 32'(reqLog.size() >= n), 32'd1);
    endtask

    task automatic waitReqLevel(input logic level, input int budget, input string name);
        int cycles = 0;
        while (bus.mem_req !== level && cycles < budget) begin
            step(1);
            cycles++;
        end
        checkOutput(name, 32'(bus.mem_req), 32'(level));
    endtask

    task automatic waitCount(input int value, input int budget, input string name);
        int cycles = 0;
        while (bus.queue_count !== 3'(value) && cycles < budget) begin
            step(1);
            cycles++;
        end
        checkOutput(name, 32'(bus.queue_count), 32'(value));
    endtask

    // Memory answers a request once it has been high for memLat cycles; forceReady injects a stray ready.
    initial begin
        int reqAge;
        reqAge        = 0;
        bus.mem_ready = 1'b0;
        bus.mem_data  = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            if (forceReady) begin
                reqAge        = 0;
                bus.mem_ready = 1'b1;
                bus.mem_data  = 32'h1BAD_B002;
            end else if (reset || !bus.mem_req) begin
                reqAge        = 0;
                bus.mem_ready = 1'b0;
            end else begin
                reqAge++;
                bus.mem_ready = (reqAge >= memLat);
                bus.mem_data  = overrideData ? DEADBEEF : memWord(bus.mem_addr);
            end
        end
    end

    // Reference model: one outstanding fetch, a FIFO of {word, pc>>2}, issue at most every other cycle.
    always @(posedge clock or posedge reset) begin
        int  preSize;
        bit  doPop;
        if (reset) begin
            mq.delete();
            m_req   = 1'b0;
            m_stale = 1'b0;
            m_pulse = 1'b0;
            m_pc    = 32'h0;
            m_addr  = 32'h0;
            m_instr = 32'h0;
            m_pcn   = 32'h0;
        end else begin
            preSize = mq.size();
            doPop   = !m_pulse && preSize > 0 && bus.available && !bus.redirect_valid;
            if (bus.redirect_valid) begin
                mq.delete();
                m_pc    = bus.redirect_pc & 32'hFFFF_FFFC;
                m_pulse = 1'b0;
                if (m_req) begin
                    if (bus.mem_ready) begin
                        m_req   = 1'b0;
                        m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end
            end else begin
                if (doPop) begin
                    m_instr = mq[0].word;
                    m_pcn   = mq[0].pcn;
                    void'(mq.pop_front());
                end
                m_pulse = doPop;
                if (m_req) begin
                    if (bus.mem_ready) begin
                        if (!m_stale) begin
                            mq.push_back('{word: bus.mem_data, pcn: m_pc >> 2});
                            m_pc = m_pc + 32'd4;
                        end
                        m_req   = 1'b0;
                        m_stale = 1'b0;
                    end
                end else if (preSize < DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = m_pc;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic prevPulse;
        logic prevReq;
        checkOutput("mem_req", 32'(bus.mem_req), 32'(m_req));
        checkOutput("mem_addr", bus.mem_addr, m_addr);
        checkOutput("decodePulse", 32'(bus.decodePulse), 32'(m_pulse));
        checkOutput("instr", bus.instr, m_instr);
        checkOutput("pcNumber", bus.pcNumber, m_pcn);
        checkOutput("queue_count", 32'(bus.queue_count), 32'(mq.size()));
        if (bus.decodePulse === 1'b1) begin
            checkOutput("pulse_spacing", 32'(prevPulse), 32'd0);
            checkOutput("dropped_word_issued", 32'(bus.instr == DEADBEEF), 32'd0);
            pulseLog.push_back('{word: bus.instr, pcn: bus.pcNumber});
        end
        if (bus.mem_req === 1'b1 && prevReq !== 1'b1) begin
            reqLog.push_back(bus.mem_addr);
        end
        prevPulse = bus.decodePulse;
        prevReq   = bus.mem_req;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Single-cycle memory, decoder always ready.
        memLat = 1;
        applyReset();
        checkOutput("t1_reset_req", 32'(bus.mem_req), 32'd0);
        checkOutput("t1_reset_count", 32'(bus.queue_count), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitPulses(3, 40, "t1_pulses_seen");
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t1_addr%0d", i), reqLog[i], 32'(4 * i));
            checkOutput($sformatf("t1_pcn%0d", i), pulseLog[i].pcn, 32'(i));
            checkOutput($sformatf("t1_word%0d", i), pulseLog[i].word, 32'hC000_0000 | 32'(4 * i));
        end

        // Stalled decoder fills the FIFO, then drains in order.
        memLat = 3;
        applyReset();
        step(40);
        checkOutput("t2_full_count", 32'(bus.queue_count), 32'd4);
        checkOutput("t2_full_req_low", 32'(bus.mem_req), 32'd0);
        checkOutput("t2_req_total", 32'(reqLog.size()), 32'd4);
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitPulses(4, 60, "t2_drain");
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2_pcn%0d", i), pulseLog[i].pcn, 32'(i));
        end
        waitReqs(5, 40, "t2_resume");
        checkOutput("t2_resume_addr", reqLog[4], 32'h10);

        // Redirect while WAIT; the late DEADBEEF word is discarded.
        memLat = 3;
        applyReset();
        overrideData = 1'b1;
        waitReqLevel(1'b1, 10, "t3_first_req");
        applyStimulus(1'b1, 32'h100, 1'b0);
        step(1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        waitReqLevel(1'b0, 10, "t3_discard_done");
        overrideData = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitReqs(2, 20, "t3_next_req");
        checkOutput("t3_redirect_addr", reqLog[1], 32'h100);
        waitPulses(1, 30, "t3_pulse");
        checkOutput("t3_pcn", pulseLog[0].pcn, 32'h40);
        checkOutput("t3_word", pulseLog[0].word, 32'hC000_0100);

        // Redirect coincides with mem_ready while two entries are queued.
        memLat = 2;
        applyReset();
        waitCount(2, 30, "t4_two_queued");
        waitReqLevel(1'b1, 10, "t4_third_req");
        step(1);
        applyStimulus(1'b1, 32'h200, 1'b0);
        reqLog.delete();
        step(1);
        checkOutput("t4_flushed_count", 32'(bus.queue_count), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitReqs(1, 20, "t4_next_req");
        checkOutput("t4_redirect_addr", reqLog[0], 32'h200);
        waitPulses(1, 30, "t4_pulse");
        checkOutput("t4_pcn", pulseLog[0].pcn, 32'h80);

        // Push and pop on the same edge at count 2, then 20 issues to wrap the pointers.
        memLat = 1;
        applyReset();
        waitCount(2, 30, "t5_two_queued");
        step(1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        step(1);
        checkOutput("t5_push_pop_count", 32'(bus.queue_count), 32'd2);
        checkOutput("t5_push_pop_pulse", 32'(bus.decodePulse), 32'd1);
        waitPulses(20, 200, "t5_twenty");
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("t5_order%0d", i), pulseLog[i].pcn, 32'(i));
        end

        // Reset during WAIT; a stray ready right after release must be ignored.
        memLat = 3;
        applyReset();
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitReqLevel(1'b1, 10, "t6_req_up");
        reset = 1'b1;
        #1;
        checkOutput("t6_req_async_drop", 32'(bus.mem_req), 32'd0);
        checkOutput("t6_pulse_low", 32'(bus.decodePulse), 32'd0);
        forceReady = 1'b1;
        step(2);
        pulseLog.delete();
        reqLog.delete();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        forceReady = 1'b0;
        waitReqs(1, 10, "t6_first_req");
        checkOutput("t6_first_addr", reqLog[0], 32'h0);
        checkOutput("t6_no_early_pulse", 32'(pulseLog.size()), 32'd0);
        waitPulses(1, 30, "t6_pulse");
        checkOutput("t6_pcn", pulseLog[0].pcn, 32'h0);
        checkOutput("t6_word", pulseLog[0].word, 32'hC000_0000);

        step(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
